// File: rtl/ramp_pkg.sv
// Shared definitions for the ramp sequencer: step-size codes, the
// code-to-increment mapping, the FSM state encoding and the ramp ceiling.
package ramp_pkg;

    // Step-size codes carried on y_cfg / Y
    localparam logic [1:0] Y0    = 2'b00;
    localparam logic [1:0] Y1    = 2'b01;
    localparam logic [1:0] Y16   = 2'b10;
    localparam logic [1:0] Y1290 = 2'b11;

    // Largest level the 12-bit ramp accumulator can represent
    localparam logic [11:0] RAMP_MAX = 12'd4095;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Increment applied to the ramp for each delta pulse
    function automatic logic [10:0] delta_y(input logic [1:0] code);
        logic [10:0] dy;
        case (code)
            Y0:      dy = 11'd0;
            Y1:      dy = 11'd1;
            Y16:     dy = 11'd16;
            Y1290:   dy = 11'd1290;
            default: dy = 11'd0;
        endcase
        return dy;
    endfunction

endpackage

// File: rtl/ramp_period_timer.sv
// Loadable down-counter that paces delta pulses. expire flags that the
// counter value taking effect at the coming edge is zero, i.e. the next
// cycle is a pulse slot; the counter then reloads on the following advance.
module ramp_period_timer #(
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                run,
    input  logic [PERIOD_W-1:0] reload,
    output logic                expire
);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] next_cnt;

    // Next counter value: load wins, otherwise count down with auto-reload
    always_comb begin
        next_cnt = cnt;
        if (load) begin
            next_cnt = reload;
        end else if (run) begin
            if (cnt == {PERIOD_W{1'b0}}) begin
                next_cnt = reload;
            end else begin
                next_cnt = cnt - {{(PERIOD_W-1){1'b0}}, 1'b1};
            end
        end else begin
            next_cnt = cnt;
        end
    end

    // Pulse slot indication for the cycle after the coming edge
    always_comb begin
        if (load || run) begin
            expire = (next_cnt == {PERIOD_W{1'b0}});
        end else begin
            expire = 1'b0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= {PERIOD_W{1'b0}};
        end else begin
            cnt <= next_cnt;
        end
    end

endmodule

// File: rtl/ramp_sequencer.sv
// Sequencer for the 12-bit ramp generator: clears the ramp, issues delta
// pulses every period clocks for num_steps steps, then holds the level.
// Optional feature macro RAMP_SEQ_SAT_GUARD_EN: when defined, the step
// count is capped so the ramp never wraps past 4095; when undefined the
// ramp and exp_val wrap modulo 4096.
module ramp_sequencer
    import ramp_pkg::*;
#(
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          y_cfg,
    input  logic [PERIOD_W-1:0] period,
    input  logic [11:0]         num_steps,
    output logic                ramp_enb,
    output logic                delta,
    output logic [1:0]          Y,
    output logic [11:0]         exp_val,
    output logic                busy,
    output logic                done
);

    state_t              state;
    logic [PERIOD_W-1:0] period_r;
    logic [11:0]         num_steps_r;
    logic [11:0]         step_cnt;

    logic [11:0]         dy12;
    logic [11:0]         exp_next;
    logic [11:0]         limit;
    logic [PERIOD_W-1:0] reload;
    logic                at_limit;
    logic                guard_block;
    logic                timer_load;
    logic                timer_run;
    logic                timer_expire;
    logic                pulse;
    logic                guard_stop;

    // Increment for the latched code and the wrapped next level
    always_comb begin
        dy12     = {1'b0, delta_y(Y)};
        exp_next = exp_val + dy12;
    end

    // Effective step limit and the would-exceed-ceiling check
    always_comb begin
        limit       = num_steps_r;
        guard_block = 1'b0;
`ifdef RAMP_SEQ_SAT_GUARD_EN
        // floor(4095/deltaY) for each non-zero code, written out as constants
        case (Y)
            Y1:      limit = num_steps_r;
            Y16:     limit = (num_steps_r > 12'd255) ? 12'd255 : num_steps_r;
            Y1290:   limit = (num_steps_r > 12'd3)   ? 12'd3   : num_steps_r;
            default: limit = num_steps_r;
        endcase
        guard_block = (({1'b0, exp_val} + {2'b00, delta_y(Y)}) > {1'b0, RAMP_MAX});
`else
        limit       = num_steps_r;
        guard_block = 1'b0;
`endif
    end

    // Timer control: period 0 behaves as 1, so the reload value saturates at 0
    always_comb begin
        if (period_r == {PERIOD_W{1'b0}}) begin
            reload = {PERIOD_W{1'b0}};
        end else begin
            reload = period_r - {{(PERIOD_W-1){1'b0}}, 1'b1};
        end
        at_limit   = (step_cnt == limit);
        timer_load = (state == ST_CLEAR) && !stop && !at_limit;
        timer_run  = (state == ST_RUN)   && !stop && !at_limit;
        pulse      = timer_expire && !guard_block;
        guard_stop = timer_expire && guard_block;
    end

    ramp_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .run    (timer_run),
        .reload (reload),
        .expire (timer_expire)
    );

    // Sequencer FSM with registered outputs, latches, step counter and level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            Y           <= 2'b00;
            period_r    <= {PERIOD_W{1'b0}};
            num_steps_r <= 12'd0;
            step_cnt    <= 12'd0;
            exp_val     <= 12'd0;
            delta       <= 1'b0;
            ramp_enb    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (stop && (state != ST_IDLE)) begin
            state    <= ST_IDLE;
            delta    <= 1'b0;
            ramp_enb <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            delta <= 1'b0;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (start && !stop) begin
                        Y           <= y_cfg;
                        period_r    <= period;
                        num_steps_r <= num_steps;
                        exp_val     <= 12'd0;
                        step_cnt    <= 12'd0;
                        state       <= ST_CLEAR;
                        ramp_enb    <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end else begin
                        // Stay put; HOLD keeps the ramp enabled and flags done
                        ramp_enb <= (state == ST_HOLD);
                        busy     <= 1'b0;
                        done     <= (state == ST_HOLD);
                    end
                end
                ST_CLEAR, ST_RUN: begin
                    if (at_limit || guard_stop) begin
                        state    <= ST_HOLD;
                        ramp_enb <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state    <= ST_RUN;
                        ramp_enb <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        if (pulse) begin
                            delta    <= 1'b1;
                            exp_val  <= exp_next;
                            step_cnt <= step_cnt + 12'd1;
                        end else begin
                            delta <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ramp_enb <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ramp_sequencer.md
# ramp_sequencer

Control block that sequences the 12-bit ramp generator. It clears the ramp, then issues delta pulses at a programmable interval for a programmable number of steps, and finally holds the final level. It latches the step-size code, tracks the expected ramp level, and optionally stops before the 12-bit accumulator would wrap. It sits between the pattern-control registers and the ramp datapath, driving its enable, delta and Y inputs.

## Interface
- PERIOD_W, default 8: width of the delta-interval input.
- clk  in  1  master clock (60 ns).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a ramp sequence.
- stop  in  1  single-cycle request to abort or release; returns the block to IDLE.
- y_cfg  in  2  step-size code, sampled on accepted start: 00→0, 01→1, 10→16, 11→1290.
- period  in  PERIOD_W  clocks between delta pulses; 0 is treated as 1. Sampled on accepted start.
- num_steps  in  12  number of delta pulses requested. Sampled on accepted start.
- ramp_enb  out  1  enable to the ramp datapath.
- delta  out  1  single-cycle increment pulse to the ramp datapath.
- Y  out  2  latched step-size code to the ramp datapath.
- exp_val  out  12  expected ramp level, updated in the same cycle delta is asserted.
- busy  out  1  high in CLEAR and RUN.
- done  out  1  high in HOLD.

## Operation
- **Outputs:** all outputs are registered.
- **States:** IDLE, CLEAR, RUN, HOLD.
- **IDLE**
  - ramp_enb=0, delta=0, busy=0, done=0.
  - On start: latch y_cfg, period and num_steps, then go to CLEAR.
- **CLEAR** (exactly one cycle)
  - ramp_enb=0, so the datapath zeroes.
  - exp_val←0; step counter←0; period timer loaded.
  - If the effective step limit is 0, go to HOLD; otherwise go to RUN.
- **RUN**
  - ramp_enb=1.
  - The period timer counts down; delta=1 in the cycle the timer expires, then the timer reloads.
  - Each pulse: exp_val←exp_val+deltaY, modulo 4096; step counter increments.
  - After the pulse that reaches the effective limit, go to HOLD.
- **HOLD**
  - ramp_enb=1 and delta=0; the ramp holds its level and exp_val is frozen.
  - done=1 until stop or start.
  - start goes to CLEAR with freshly latched inputs.
- **stop:** in any non-IDLE state, go to IDLE next cycle; delta is never asserted in that cycle.
- **start/stop collision:** if both arrive in the same cycle, stop wins.
- **Ignored inputs:** start in CLEAR or RUN is ignored. Changes to y_cfg, period or num_steps after acceptance have no effect.
- **Y=00:** pulses are still issued (num_steps of them) and exp_val stays 0.
- **Arithmetic:**
  - deltaY is 11 bits and is zero-extended to 13 bits for the guard comparison.
  - The step counter is 12 bits and never wraps, because the limit is at most 4095.

## Timing
- **Reset values:** ramp_enb=0, delta=0, Y=00, exp_val=0, busy=0, done=0; state=IDLE.
- **Start latency:** start sampled at edge N → CLEAR visible after N+1 → RUN after N+2.
- **First pulse:** the first delta is asserted for the cycle after edge N+1+period_eff, where period_eff=max(period,1).
- **Pulse spacing:** consecutive deltas are exactly period_eff cycles apart. With period_eff=1, delta is high continuously for limit cycles.
- **Pulse to HOLD:** HOLD is entered on the edge that ends the final delta cycle.
- **Reset mid-operation:** asynchronous reset, mid-sequence, forces all outputs to their reset values immediately.

## Configuration
- **Macro:** RAMP_SEQ_SAT_GUARD_EN.
- **Defined:** the effective limit is min(num_steps, floor(4095/deltaY)); a pulse is suppressed, and HOLD entered, when exp_val+deltaY (13-bit sum) would exceed 4095. For Y=00 the limit is num_steps.
- **Undefined:** the effective limit is num_steps. The ramp and exp_val wrap modulo 4096.

## Structure
- **Shared package ramp_pkg:**
  - Y code constants Y0/Y1/Y16/Y1290.
  - Code-to-deltaY mapping function, 11-bit.
  - State encoding.
  - Constant RAMP_MAX=4095.
- **Sub-module ramp_period_timer:** loadable down-counter of width PERIOD_W with an expire pulse and auto-reload. It is the natural split.
- **Top-level contents:** FSM, latches, step counter, exp_val accumulator and guard compare remain in the top level.

## Test plan
- **Basic run:** y_cfg=01, period=1, num_steps=5. Expect 5 consecutive delta cycles, exp_val=5, then done=1 with ramp_enb=1.
- **Guard defined:** y_cfg=11, period=3, num_steps=10. Expect exactly 3 pulses spaced 3 cycles apart, exp_val=3870, then HOLD.
- **Guard undefined:** same stimulus as above. Expect 10 pulses and exp_val=(10×1290) mod 4096=612.
- **Zero steps:** num_steps=0. Expect CLEAR → HOLD, zero deltas, done two cycles after start.
- **Stop mid-run:** y_cfg=10, period=2, stop after the 4th pulse. Expect IDLE next cycle, ramp_enb=0, exp_val=64 retained, no further delta.
- **Reset and restart:** assert rst_n=0 mid-RUN; expect reset values immediately. After release, start with y_cfg=01 while toggling y_cfg during RUN; Y stays 01 throughout.
